// File: rtl/ones_mod10_stage.sv
// Units-digit (mod-10) stage of the countdown timer: prescaler, digit decrement,
// borrow pulse to the tens stage and the start/pause/done control FSM.
module ones_mod10_stage #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clock,
  input  logic       clr,
  input  logic [3:0] data,
  input  logic       loadn,
  input  logic       start,
  input  logic       pause,
  input  logic       tens_zero,
  output logic [3:0] ones,
  output logic       tens_en,
  output logic       running,
  output logic       done
);
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tens_en_q, tens_en_d;
  logic          done_q, done_d;
  logic          running_q;
  logic          load, tick;

  assign load = !loadn && (state_q != RUN);
  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    presc_d   = presc_q;
    tens_en_d = 1'b0;
    done_d    = done_q;
    if (load) begin
      ones_d  = (data > 4'd9) ? 4'd9 : data;
      state_d = IDLE;
      done_d  = 1'b0;
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          if (ones_q == 4'd0 && tens_zero) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          // pause wins over a coincident tick; prescaler is held for resume
          if (pause) begin
            state_d = PAUSE;
          end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
              if (ones_q > 4'd1) begin
                ones_d = ones_q - 4'd1;
              end else if (ones_q == 4'd1) begin
                ones_d = 4'd0;
                if (tens_zero) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                end
              end else if (!tens_zero) begin
                ones_d    = 4'd9;
                tens_en_d = 1'b1;
              end else begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
        PAUSE: if (pause || start) state_d = RUN;
        DONE:  done_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      state_q   <= IDLE;
      ones_q    <= 4'd0;
      presc_q   <= '0;
      tens_en_q <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      presc_q   <= presc_d;
      tens_en_q <= tens_en_d;
      done_q    <= done_d;
      running_q <= (state_d == RUN);
    end
  end

  assign ones    = ones_q;
  assign tens_en = tens_en_q;
  assign running = running_q;
  assign done    = done_q;
endmodule

// File: tb/tb_ones_mod10_stage.sv
// Directed bench for ones_mod10_stage (TICK_DIV=4); expectations are queued as
// each step is driven and checked after the following rising edge.
module tb_ones_mod10_stage;
  logic       clock = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] data = 4'd0;
  logic       loadn = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       tens_zero = 1'b1;
  logic [3:0] ones;
  logic       tens_en, running, done;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      tag;
    logic [6:0] v;  // {ones, tens_en, running, done}
  } exp_t;
  exp_t sb[$];

  ones_mod10_stage #(.TICK_DIV(4)) dut (
    .clock(clock), .clr(clr), .data(data), .loadn(loadn), .start(start),
    .pause(pause), .tens_zero(tens_zero), .ones(ones), .tens_en(tens_en),
    .running(running), .done(done)
  );

  always #5 clock = ~clock;

  task automatic push(input string tag, input logic [3:0] o, input logic te,
                      input logic r, input logic d);
    exp_t e;
    e.tag = tag;
    e.v   = {o, te, r, d};
    sb.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    logic [6:0] obs;
    @(posedge clock);
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = {ones, tens_en, running, done};
      total++;
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s: got ones=%0d te=%b run=%b done=%b, want ones=%0d te=%b run=%b done=%b",
               e.tag, obs[6:3], obs[2], obs[1], obs[0], e.v[6:3], e.v[2], e.v[1], e.v[0]);
      end
    end
  endtask

  // expect the same outputs for n consecutive edges
  task automatic hold(input string tag, input int n, input logic [3:0] o,
                      input logic te, input logic r, input logic d);
    for (int i = 0; i < n; i++) begin
      push(tag, o, te, r, d);
      cyc();
    end
  endtask

  initial begin
    logic [3:0] val;

    // reset from power-up
    hold("rst", 2, 4'd0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;

    // saturating load in IDLE
    loadn = 1'b0; data = 4'd12;
    push("ld_sat", 4'd9, 1'b0, 1'b0, 1'b0); cyc();
    // load beats start in the same cycle
    data = 4'd3; start = 1'b1;
    push("ld_start", 4'd3, 1'b0, 1'b0, 1'b0); cyc();
    loadn = 1'b1; start = 1'b0;
    hold("idle_hold", 1, 4'd3, 1'b0, 1'b0, 1'b0);

    // short countdown 3 -> 0 with tens_zero=1
    tens_zero = 1'b1; start = 1'b1;
    push("run_enter", 4'd3, 1'b0, 1'b1, 1'b0); cyc();
    start = 1'b0;
    val = 4'd3;
    for (int t = 0; t < 3; t++) begin
      hold("cnt_wait", 3, val, 1'b0, 1'b1, 1'b0);
      val = val - 4'd1;
      if (val == 4'd0) push("cnt_done", 4'd0, 1'b0, 1'b0, 1'b1);
      else             push("cnt_dec", val, 1'b0, 1'b1, 1'b0);
      cyc();
    end
    // DONE ignores start and pause
    start = 1'b1; pause = 1'b1;
    hold("done_hold", 2, 4'd0, 1'b0, 1'b0, 1'b1);
    start = 1'b0; pause = 1'b0;

    // load from DONE, start, load ignored in RUN, then clr mid-RUN
    loadn = 1'b0; data = 4'd7;
    push("ld_from_done", 4'd7, 1'b0, 1'b0, 1'b0); cyc();
    loadn = 1'b1; start = 1'b1;
    push("run7", 4'd7, 1'b0, 1'b1, 1'b0); cyc();
    start = 1'b0; loadn = 1'b0; data = 4'd2;
    push("ld_in_run", 4'd7, 1'b0, 1'b1, 1'b0); cyc();
    loadn = 1'b1;
    clr = 1'b1;
    hold("clr_run", 2, 4'd0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;

    // borrow from 0 with tens_zero=0
    loadn = 1'b0; data = 4'd0;
    push("ld0", 4'd0, 1'b0, 1'b0, 1'b0); cyc();
    loadn = 1'b1; tens_zero = 1'b0; start = 1'b1;
    push("run0", 4'd0, 1'b0, 1'b1, 1'b0); cyc();
    start = 1'b0;
    hold("pre_borrow", 3, 4'd0, 1'b0, 1'b1, 1'b0);
    push("borrow", 4'd9, 1'b1, 1'b1, 1'b0); cyc();
    hold("post_borrow", 3, 4'd9, 1'b0, 1'b1, 1'b0);
    push("dec_8", 4'd8, 1'b0, 1'b1, 1'b0); cyc();

    // pause two cycles into the tick period, hold 20 cycles, resume
    hold("pre_pause", 2, 4'd8, 1'b0, 1'b1, 1'b0);
    pause = 1'b1;
    push("pause", 4'd8, 1'b0, 1'b0, 1'b0); cyc();
    pause = 1'b0;
    hold("paused", 20, 4'd8, 1'b0, 1'b0, 1'b0);
    pause = 1'b1;
    push("resume", 4'd8, 1'b0, 1'b1, 1'b0); cyc();
    pause = 1'b0;
    push("resume_wait", 4'd8, 1'b0, 1'b1, 1'b0); cyc();
    push("resume_dec", 4'd7, 1'b0, 1'b1, 1'b0); cyc();

    // immediate done from IDLE with 00, then reload
    clr = 1'b1;
    push("rst2", 4'd0, 1'b0, 1'b0, 1'b0); cyc();
    clr = 1'b0; tens_zero = 1'b1; start = 1'b1;
    push("imm_done", 4'd0, 1'b0, 1'b0, 1'b1); cyc();
    start = 1'b0;
    hold("imm_hold", 1, 4'd0, 1'b0, 1'b0, 1'b1);
    loadn = 1'b0; data = 4'd5;
    push("ld_clr_done", 4'd5, 1'b0, 1'b0, 1'b0); cyc();
    loadn = 1'b1; pause = 1'b1;
    push("idle_pause", 4'd5, 1'b0, 1'b0, 1'b0); cyc();
    pause = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
